// File: rtl/toggle_activity_monitor.sv
// toggle_activity_monitor: counts per-bit toggles over windows of enabled cycles,
// freezes them into a shadow bank and streams the bank out over valid/ready.
module toggle_activity_monitor #(
    parameter int WIDTH  = 23,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 1024,
    parameter int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] sample,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_count,
    output logic             rd_last,
    output logic             overflow
);
    localparam int WIN_W = $clog2(WINDOW);
    localparam logic IDLE = 1'b0;
    localparam logic DUMP = 1'b1;

    logic             state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             overflow_q, overflow_d;
    logic             primed_q, primed_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [CNT_W-1:0] cnt_inc [WIDTH];
    logic [CNT_W-1:0] shadow_q [WIDTH];
    logic [CNT_W-1:0] shadow_d [WIDTH];
    logic [WIDTH-1:0] toggle;
    logic             win_end, last, accept;

    always_comb begin
        toggle     = (en && primed_q) ? sample ^ prev_q : '0;
        win_end    = en && (win_q == WIN_W'(WINDOW - 1));
        prev_d     = en ? sample : prev_q;
        primed_d   = primed_q | en;
        win_d      = win_end ? '0 : (en ? win_q + 1'b1 : win_q);
        for (int i = 0; i < WIDTH; i++) begin
            cnt_inc[i]  = (toggle[i] && cnt_q[i] != '1) ? cnt_q[i] + 1'b1 : cnt_q[i];
            cnt_d[i]    = win_end ? '0 : cnt_inc[i];
            shadow_d[i] = (win_end && state_q == IDLE) ? cnt_inc[i] : shadow_q[i];
        end
        // A window closing while a dump is still running is dropped, even on the final accept
        overflow_d = overflow_q | (win_end && state_q == DUMP);
        last       = idx_q == IDX_W'(WIDTH - 1);
        accept     = state_q == DUMP && rd_ready;
        state_d    = (state_q == IDLE) ? (win_end ? DUMP : IDLE) : ((accept && last) ? IDLE : DUMP);
        idx_d      = (state_q == IDLE) ? '0 : (accept ? (last ? '0 : idx_q + 1'b1) : idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            primed_q   <= 1'b0;
            prev_q     <= '0;
            win_q      <= '0;
            cnt_q      <= '{default: '0};
            shadow_q   <= '{default: '0};
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            primed_q   <= primed_d;
            prev_q     <= prev_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
        end
    end

    assign rd_valid = state_q;
    assign rd_idx   = idx_q;
    assign rd_count = rd_valid ? shadow_q[idx_q] : '0;
    assign rd_last  = rd_valid && last;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_toggle_activity_monitor.sv
// tb_toggle_activity_monitor: drives a 4-bit/4-count and a 4-bit/2-count monitor
// with shared stimulus and scores both against a window-level reference model.
module tb_toggle_activity_monitor;
    localparam int W   = 4;
    localparam int WIN = 8;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, rd_ready = 1'b0;
    logic [W-1:0] sample = '0;
    logic rd_valid, rd_last, overflow, s_valid, s_last, s_ovf;
    logic [1:0] rd_idx, s_idx;
    logic [3:0] rd_count;
    logic [1:0] s_count;
    int n_cmp = 0, n_err = 0;

    int m_live [2][W];
    int m_shadow [2][W];
    int m_max [2] = '{15, 3};
    logic [W-1:0] m_prev;
    bit m_primed, m_busy, m_ovf;
    int m_win, m_idx;

    toggle_activity_monitor #(.WIDTH(W), .CNT_W(4), .WINDOW(WIN)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sample(sample), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_idx(rd_idx), .rd_count(rd_count), .rd_last(rd_last),
        .overflow(overflow));

    toggle_activity_monitor #(.WIDTH(W), .CNT_W(2), .WINDOW(WIN)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .sample(sample), .rd_valid(s_valid),
        .rd_ready(rd_ready), .rd_idx(s_idx), .rd_count(s_count), .rd_last(s_last),
        .overflow(s_ovf));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < W; i++) begin
                m_live[k][i] = 0;
                m_shadow[k][i] = 0;
            end
        m_prev = '0;
        m_primed = 0;
        m_busy = 0;
        m_ovf = 0;
        m_win = 0;
        m_idx = 0;
    endtask

    // One clock of the behavioural model: count changes between consecutive enabled samples,
    // close a window after WIN enabled samples, and hand it to the reader if it is free.
    task automatic model_edge();
        bit wend = 0;
        bit was_busy = m_busy;
        if (en) begin
            if (m_primed)
                for (int i = 0; i < W; i++)
                    if (sample[i] != m_prev[i])
                        for (int k = 0; k < 2; k++)
                            if (m_live[k][i] < m_max[k]) m_live[k][i]++;
            m_prev = sample;
            m_primed = 1;
            m_win++;
            wend = (m_win == WIN);
        end
        if (m_busy && rd_ready) begin
            if (m_idx == W - 1) m_busy = 0;
            else m_idx++;
        end
        if (wend) begin
            if (was_busy) m_ovf = 1;
            else begin
                m_shadow = m_live;
                m_busy = 1;
                m_idx = 0;
            end
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < W; i++) m_live[k][i] = 0;
            m_win = 0;
        end
    endtask

    task automatic check_all();
        chk("valid", rd_valid, m_busy);
        chk("valid_s", s_valid, m_busy);
        chk("ovf", overflow, m_ovf);
        chk("ovf_s", s_ovf, m_ovf);
        if (m_busy) begin
            chk("idx", rd_idx, m_idx);
            chk("idx_s", s_idx, m_idx);
            chk("last", rd_last, m_idx == W - 1);
            chk("last_s", s_last, m_idx == W - 1);
            chk("count", rd_count, m_shadow[0][m_idx]);
            chk("count_s", s_count, m_shadow[1][m_idx]);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, rd_valid, 0);
        chk({tag, "_idx"}, rd_idx, 0);
        chk({tag, "_count"}, rd_count, 0);
        chk({tag, "_last"}, rd_last, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_valid_s"}, s_valid, 0);
        chk({tag, "_count_s"}, s_count, 0);
        chk({tag, "_ovf_s"}, s_ovf, 0);
    endtask

    task automatic tick(input logic e, input logic [W-1:0] s, input logic r);
        en = e;
        sample = s;
        rd_ready = r;
        @(posedge clk);
        if (rst_n) model_edge();
        #1 check_all();
        @(negedge clk);
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && m_busy; n++) tick(1'b0, sample, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1 chk_reset(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1 chk_reset("rst");
        @(posedge clk);
        #1 chk_reset("rst2");
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < WIN; t++) tick(1'b1, (t % 2 == 0) ? 4'b0000 : 4'b1111, 1'b1);
        chk("prime_valid", rd_valid, 1);
        chk("prime_cnt", rd_count, 7);
        chk("prime_cnt_s", s_count, 3);
        drain();

        for (int t = 0; t < 3 * WIN; t++) tick(1'b1, 4'(t & 1), 1'b1);
        drain();

        for (int t = 0; t < WIN; t++) tick(1'b1, 4'($urandom), 1'b0);
        for (int t = 0; t < 5; t++) tick(1'b0, sample, 1'b0);
        chk("bp_valid", rd_valid, 1);
        chk("bp_idx", rd_idx, 0);
        for (int t = 0; t < W; t++) tick(1'b0, sample, 1'b1);
        chk("bp_done", rd_valid, 0);

        for (int t = 0; t < 2 * WIN; t++) tick(t % 2 == 1, (t % 2 == 0) ? 4'b1111 : 4'b0000, 1'b1);
        chk("engate_close", rd_valid, 1);
        drain();

        for (int t = 0; t < WIN; t++) tick(1'b1, 4'($urandom), 1'b0);
        for (int t = 0; t < WIN + 1; t++) tick(1'b1, 4'($urandom), 1'b0);
        chk("ovf_set", overflow, 1);
        for (int t = 0; t < 2 * WIN - 1; t++) tick(1'b1, 4'($urandom), 1'b1);
        drain();

        for (int n = 0; n < 40 && !(m_busy && m_idx == 2); n++) tick(1'b1, 4'($urandom), 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_reset("arst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < WIN - 1; t++) tick(1'b1, 4'($urandom), 1'b1);
        chk("arst_nodump", rd_valid, 0);
        tick(1'b1, 4'($urandom), 1'b1);
        chk("arst_dump", rd_valid, 1);
        drain();

        for (int t = 0; t < WIN; t++) tick(1'b1, 4'($urandom), 1'b0);
        for (int t = 0; t < 4; t++) tick(1'b1, 4'($urandom), 1'b0);
        for (int t = 0; t < 3; t++) tick(1'b0, sample, 1'b1);
        for (int t = 0; t < 3; t++) tick(1'b1, 4'($urandom), 1'b0);
        tick(1'b1, 4'($urandom), 1'b1);
        chk("same_edge_ovf", overflow, 1);
        chk("same_edge_idle", rd_valid, 0);

        @(negedge clk);
        do_reset("rst3");
        for (int t = 0; t < 400; t++)
            tick($urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom_range(0, 1)));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
